imm_extend_stage: RTL and testbench

// - Decode-stage immediate controller for the pipelined LEGv8 core; sits between the IF/ID

---
 rtl/imm_pkg.sv | 57 +++++
 rtl/imm_extend_stage_if.sv | 33 +++
 rtl/imm_decode.sv | 46 ++++
 rtl/imm_extend_stage.sv | 93 +++++++++
 tb/tb_imm_extend_stage.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate extender.
// Provides datapath widths, the immediate format code, the opcode match
// constants used by imm_decode, the per-instruction result bundle, and the
// skid buffer state encoding.
package imm_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_D    = 3'd1,
    IMM_CB   = 3'd2,
    IMM_B    = 3'd3,
    IMM_I    = 3'd4,
    IMM_IW   = 3'd5
  } imm_type_t;

  // D format, instr[31:21]
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CB format, instr[31:24]
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  // B format, instr[31:26]
  localparam logic [5:0]  OP_B  = 6'b000101;
  localparam logic [5:0]  OP_BL = 6'b100101;
  // I format, instr[31:22]
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  // IW format, instr[31:23]
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    imm_type_t       imm_type;
    logic            illegal;
  } imm_bundle_t;

  localparam imm_bundle_t BUNDLE_RESET = '{
    imm:      '0,
    target:   '0,
    imm_type: IMM_NONE,
    illegal:  1'b0
  };

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/imm_extend_stage_if.sv
// Bus between the IF/ID register, the immediate stage and the ID/EX register.
// Ports (signals):
//   in_valid/in_ready/in_instr/in_pc : upstream valid/ready handshake
//   flush                            : kill held and incoming entries
//   out_valid/out_ready              : downstream valid/ready handshake
//   out_imm/out_target/out_imm_type/out_illegal : result bundle
// Modports: master = surrounding pipeline, slave = the immediate stage.
interface imm_extend_stage_if;
  import imm_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [XLEN-1:0]    in_pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_imm;
  logic [XLEN-1:0]    out_target;
  imm_type_t          out_imm_type;
  logic               out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_target, out_imm_type, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_imm, out_target, out_imm_type, out_illegal
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate decoder: classifies an instruction by immediate
// format, extends the immediate to XLEN and computes the branch target.
// Ports:
//   instr  in   instruction word
//   pc     in   PC of instr
//   bundle out  {imm, target, imm_type, illegal}
module imm_decode
  import imm_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  logic [XLEN-1:0]    pc,
  output imm_bundle_t        bundle
);

  always_comb begin
    bundle = BUNDLE_RESET;
    if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      bundle.imm_type = IMM_D;
      bundle.imm      = {{(XLEN-9){instr[20]}}, instr[20:12]};
    end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ ||
                 instr[31:24] == OP_BCOND) begin
      // Word offset -> byte offset.
      bundle.imm_type = IMM_CB;
      bundle.imm      = {{(XLEN-21){instr[23]}}, instr[23:5], 2'b00};
    end else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
      bundle.imm_type = IMM_B;
      bundle.imm      = {{(XLEN-28){instr[25]}}, instr[25:0], 2'b00};
    end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI ||
                 instr[31:22] == OP_ANDI || instr[31:22] == OP_ORRI) begin
      bundle.imm_type = IMM_I;
      bundle.imm      = {{(XLEN-12){1'b0}}, instr[21:10]};
    end else if (instr[31:23] == OP_MOVZ) begin
      // hw field selects which 16-bit lane receives the literal.
      bundle.imm_type = IMM_IW;
      bundle.imm      = {{(XLEN-16){1'b0}}, instr[20:5]} << {instr[22:21], 4'b0000};
    end else begin
      // Unknown opcodes still flow; the exception is raised further down.
      bundle.illegal = 1'b1;
    end

    if (bundle.imm_type == IMM_CB || bundle.imm_type == IMM_B) begin
      bundle.target = pc + bundle.imm;
    end
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Decode-stage immediate controller. Decodes the incoming instruction and
// presents the result through a 2-entry valid/ready skid buffer so that an
// ID/EX stall never forms a combinational path back to fetch.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset (priority over flush)
//   io     slave side of imm_extend_stage_if (handshakes, flush, results)
module imm_extend_stage
  import imm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  imm_extend_stage_if.slave io
);

  imm_bundle_t dec_bundle;
  imm_bundle_t head_q, head_d;
  imm_bundle_t tail_q, tail_d;
  skid_state_t state_q, state_d;
  logic        in_ready;
  logic        out_valid;
  logic        accept;
  logic        transfer;

  imm_decode u_decode (
    .instr  (io.in_instr),
    .pc     (io.in_pc),
    .bundle (dec_bundle)
  );

  // Depends on registered state only, never on out_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = io.in_valid && in_ready;
  assign transfer  = out_valid && io.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (io.flush) begin
      // Flush wins over accept/transfer; a coincident transfer already
      // completed downstream.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_d  = dec_bundle;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && transfer) begin
            head_d = dec_bundle;
          end else if (accept) begin
            tail_d  = dec_bundle;
            state_d = ST_TWO;
          end else if (transfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (transfer) begin
            head_d  = tail_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      head_q  <= BUNDLE_RESET;
      tail_q  <= BUNDLE_RESET;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign io.in_ready     = in_ready;
  assign io.out_valid    = out_valid;
  assign io.out_imm      = head_q.imm;
  assign io.out_target   = head_q.target;
  assign io.out_imm_type = head_q.imm_type;
  assign io.out_illegal  = head_q.illegal;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed testbench for imm_extend_stage with a scoreboard queue: expected
// bundles are pushed on accept and popped on each downstream transfer.
module tb_imm_extend_stage;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  imm_extend_stage_if bus ();

  imm_extend_stage dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  imm_bundle_t exp_q[$];
  imm_bundle_t exp_cur;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic imm_bundle_t mk(input logic [63:0] imm, input logic [63:0] target,
                                     input imm_type_t t, input logic ill);
    imm_bundle_t b;
    b.imm      = imm;
    b.target   = target;
    b.imm_type = t;
    b.illegal  = ill;
    return b;
  endfunction

  task automatic offer(input logic [31:0] instr, input logic [63:0] pc, input imm_bundle_t exp);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    exp_cur      = exp;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc    = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_imm"},       bus.out_imm, 64'd0);
    check({tag, "_target"},    bus.out_target, 64'd0);
    check({tag, "_type"},      64'(bus.out_imm_type), 64'(IMM_NONE));
    check({tag, "_illegal"},   64'(bus.out_illegal), 64'd0);
  endtask

  // One clock: sample handshakes #1 after the previous edge, update the
  // scoreboard, then advance to #1 after the next edge.
  task automatic tick();
    imm_bundle_t exp;
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        check("sb_expected_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          $display("[%0t] xfer imm=0x%h target=0x%h type=%0d illegal=%0d",
                   $time, bus.out_imm, bus.out_target, bus.out_imm_type, bus.out_illegal);
          check("sb_imm",     bus.out_imm, exp.imm);
          check("sb_target",  bus.out_target, exp.target);
          check("sb_type",    64'(bus.out_imm_type), 64'(exp.imm_type));
          check("sb_illegal", 64'(bus.out_illegal), 64'(exp.illegal));
        end
      end
      if (bus.flush) exp_q.delete();
      else if (bus.in_valid && bus.in_ready) exp_q.push_back(exp_cur);
    end
    @(posedge clk);
    #1;
    if (reset) exp_q.delete();
  endtask

  task automatic drain(input int budget);
    idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("drain_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  localparam logic [63:0] NEG8  = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] NEG16 = 64'hFFFF_FFFF_FFFF_FFF0;
  localparam logic [63:0] NEG4  = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    exp_cur       = BUNDLE_RESET;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // LDUR: one-cycle latency
    bus.out_ready = 1'b1;
    offer(32'hF85F8041, 64'h0, mk(NEG8, 64'h0, IMM_D, 1'b0));
    tick();
    check("ldur_latency_valid", 64'(bus.out_valid), 64'd1);
    check("ldur_imm_direct", bus.out_imm, NEG8);

    // Back-to-back stream of all formats
    offer(32'hB4FFFF83, 64'h100, mk(NEG16, 64'hF0, IMM_CB, 1'b0));            tick();
    offer(32'h14000010, 64'h200, mk(64'h40, 64'h240, IMM_B, 1'b0));          tick();
    offer(32'h913FFC00, 64'h300, mk(64'hFFF, 64'h0, IMM_I, 1'b0));           tick();
    offer(32'hD2C24680, 64'h304, mk(64'h0000_1234_0000_0000, 64'h0, IMM_IW, 1'b0)); tick();
    offer(32'hF80FF000, 64'h308, mk(64'hFF, 64'h0, IMM_D, 1'b0));            tick();
    offer(32'hB2048C00, 64'h30C, mk(64'h123, 64'h0, IMM_I, 1'b0));           tick();
    offer(32'h97FFFFFF, 64'h1000, mk(NEG4, 64'hFFC, IMM_B, 1'b0));           tick();
    offer(32'h54000040, 64'h10, mk(64'h8, 64'h18, IMM_CB, 1'b0));            tick();
    offer(32'h14000010, 64'hFFFF_FFFF_FFFF_FFF0, mk(64'h40, 64'h30, IMM_B, 1'b0)); tick();
    offer(32'h00000000, 64'h400, mk(64'h0, 64'h0, IMM_NONE, 1'b1));          tick();
    check("stream_in_ready", 64'(bus.in_ready), 64'd1);
    check("illegal_flag_direct", 64'(bus.out_illegal), 64'd1);
    drain(8);

    // Backpressure: two accepts then in_ready drops
    bus.out_ready = 1'b0;
    offer(32'h91000400, 64'h0, mk(64'h1, 64'h0, IMM_I, 1'b0)); tick();
    check("bp_in_ready_one", 64'(bus.in_ready), 64'd1);
    offer(32'h91000800, 64'h0, mk(64'h2, 64'h0, IMM_I, 1'b0)); tick();
    check("bp_in_ready_two", 64'(bus.in_ready), 64'd0);
    offer(32'h91000C00, 64'h0, mk(64'h3, 64'h0, IMM_I, 1'b0)); tick();
    check("bp_in_ready_held", 64'(bus.in_ready), 64'd0);
    check("bp_head_stable", bus.out_imm, 64'h1);
    bus.out_ready = 1'b1;
    tick();
    check("bp_in_ready_reopen", 64'(bus.in_ready), 64'd1);
    check("bp_second_valid", 64'(bus.out_valid), 64'd1);
    tick();
    idle();
    check("bp_third_valid", 64'(bus.out_valid), 64'd1);
    drain(4);

    // Flush while TWO with an incoming offer
    bus.out_ready = 1'b0;
    offer(32'h91001000, 64'h0, mk(64'h4, 64'h0, IMM_I, 1'b0)); tick();
    offer(32'h91001400, 64'h0, mk(64'h5, 64'h0, IMM_I, 1'b0)); tick();
    offer(32'h91001800, 64'h0, mk(64'h6, 64'h0, IMM_I, 1'b0));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (4) tick();

    // Flush coinciding with a transfer
    offer(32'h91001C00, 64'h0, mk(64'h7, 64'h0, IMM_I, 1'b0)); tick();
    offer(32'h91002000, 64'h0, mk(64'h8, 64'h0, IMM_I, 1'b0));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    check("flush_xfer_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (3) tick();

    // Reset mid-stream
    bus.out_ready = 1'b0;
    offer(32'h14000010, 64'h200, mk(64'h40, 64'h240, IMM_B, 1'b0)); tick();
    offer(32'hB4FFFF83, 64'h100, mk(NEG16, 64'hF0, IMM_CB, 1'b0)); tick();
    offer(32'h91000400, 64'h0, mk(64'h1, 64'h0, IMM_I, 1'b0));
    reset = 1'b1;
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    repeat (2) tick();

    // Recovery after reset
    offer(32'hF85F8041, 64'h0, mk(NEG8, 64'h0, IMM_D, 1'b0));
    tick();
    check("recover_valid", 64'(bus.out_valid), 64'd1);
    drain(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
